// File: rtl/pc_sequencer.sv
// Multi-cycle control sequencer: steps IF/ID/EXE/MEM/WB, computes the next PC
// and the PC/IR write enables, and counts retired instructions.
module pc_sequencer (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] PCCur,
    input  logic [31:0] Instr,
    input  logic        Zero,
    input  logic [31:0] RegA,
    output logic [31:0] PCNext,
    output logic        PCWE,
    output logic        IRWE,
    output logic [2:0]  State,
    output logic        Halted,
    output logic [31:0] InstrCount
);
    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EXE  = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_HALT  = 6'b111111;
    localparam logic [5:0] FN_JR    = 6'b001000;

    state_t      state_q, state_d;
    logic [31:0] pc4_q, cnt_q;
    logic [31:0] pc_inc, j_tgt, br_tgt;
    logic [5:0]  op, funct;

    assign op     = Instr[31:26];
    assign funct  = Instr[5:0];
    assign pc_inc = PCCur + 32'd4;
    assign j_tgt  = {pc4_q[31:28], Instr[25:0], 2'b00};
    assign br_tgt = pc4_q + {{14{Instr[15]}}, Instr[15:0], 2'b00};

    always_comb begin
        state_d = S_IF;
        PCWE    = 1'b0;
        IRWE    = 1'b0;
        PCNext  = pc4_q;
        case (state_q)
            S_IF: begin
                IRWE    = 1'b1;
                PCWE    = 1'b1;
                PCNext  = pc_inc;
                state_d = S_ID;
            end
            S_ID: begin
                case (op)
                    OP_J: begin
                        PCWE    = 1'b1;
                        PCNext  = j_tgt;
                        state_d = S_IF;
                    end
                    OP_JAL: begin
                        PCWE    = 1'b1;
                        PCNext  = j_tgt;
                        state_d = S_WB;
                    end
                    OP_RTYPE: begin
                        if (funct == FN_JR) begin
                            PCWE    = 1'b1;
                            PCNext  = RegA;
                            state_d = S_IF;
                        end else begin
                            state_d = S_EXE;
                        end
                    end
                    OP_LW, OP_SW, OP_BEQ, OP_BNE: state_d = S_EXE;
                    OP_HALT: state_d = S_HALT;
                    default: state_d = S_IF;
                endcase
            end
            S_EXE: begin
                case (op)
                    // Both branch flavours return to IF; only the taken one writes the PC.
                    OP_BEQ: begin
                        PCWE    = Zero;
                        PCNext  = Zero ? br_tgt : pc4_q;
                        state_d = S_IF;
                    end
                    OP_BNE: begin
                        PCWE    = !Zero;
                        PCNext  = Zero ? pc4_q : br_tgt;
                        state_d = S_IF;
                    end
                    OP_RTYPE:     state_d = S_WB;
                    OP_LW, OP_SW: state_d = S_MEM;
                    default:      state_d = S_IF;
                endcase
            end
            S_MEM:   state_d = (op == OP_LW) ? S_WB : S_IF;
            S_WB:    state_d = S_IF;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IF;
        endcase
        if (RST) begin
            PCWE = 1'b0;
            IRWE = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IF;
            pc4_q   <= 32'd0;
            cnt_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IF)
                pc4_q <= pc_inc;
            // An instruction retires when control returns to fetch.
            if (state_d == S_IF && state_q != S_IF)
                cnt_q <= cnt_q + 32'd1;
        end
    end

    assign State      = state_q;
    assign Halted     = (state_q == S_HALT);
    assign InstrCount = cnt_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: per-cycle expected state/enables/next-PC
// are queued as stimulus is set up and compared on the falling edge.
module tb_pc_sequencer;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] PCCur = 32'd0;
    logic [31:0] Instr = 32'd0;
    logic        Zero = 1'b0;
    logic [31:0] RegA = 32'd0;
    logic [31:0] PCNext;
    logic        PCWE, IRWE, Halted;
    logic [2:0]  State;
    logic [31:0] InstrCount;

    typedef struct packed {
        logic [2:0]  st;
        logic        we;
        logic        ir;
        logic [31:0] pc;
    } exp_t;

    exp_t        sb[$];
    int          n_run = 0;
    int          n_fail = 0;
    logic [31:0] exp_cnt = 32'd0;

    localparam logic [31:0] I_NOP  = {6'b001000, 26'd0};
    localparam logic [31:0] I_HALT = {6'b111111, 26'd0};
    localparam logic [31:0] I_LW   = {6'b100011, 26'd0};

    pc_sequencer dut (
        .CLK(CLK), .RST(RST), .PCCur(PCCur), .Instr(Instr), .Zero(Zero), .RegA(RegA),
        .PCNext(PCNext), .PCWE(PCWE), .IRWE(IRWE), .State(State), .Halted(Halted),
        .InstrCount(InstrCount)
    );

    always #5 CLK = ~CLK;

    task automatic push(input logic [2:0] st, input logic we, input logic ir, input logic [31:0] pc);
        exp_t e;
        e.st = st; e.we = we; e.ir = ir; e.pc = pc;
        sb.push_back(e);
    endtask

    task automatic test_reset;
        exp_t e;
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        n_run++;
        if ({State, PCWE, IRWE, InstrCount} !== {3'd0, 1'b0, 1'b0, 32'd0}) begin
            n_fail++;
            $display("FAIL reset_hold: st=%0d we=%b ir=%b cnt=%h, expected st=0 we=0 ir=0 cnt=0",
                     State, PCWE, IRWE, InstrCount);
        end
        @(posedge CLK); #1;
        RST = 1'b0; PCCur = 32'h0; Instr = I_NOP;
        push(3'd0, 1'b1, 1'b1, 32'h4);
        push(3'd1, 1'b0, 1'b0, 32'h4);
        exp_cnt = 32'd1;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            @(negedge CLK);
            n_run++;
            if ({State, PCWE, IRWE, PCNext, Halted} !== {e.st, e.we, e.ir, e.pc, e.st == 3'd5}) begin
                n_fail++;
                $display("FAIL reset_first: st=%0d we=%b ir=%b pc=%h hl=%b, expected st=%0d we=%b ir=%b pc=%h",
                         State, PCWE, IRWE, PCNext, Halted, e.st, e.we, e.ir, e.pc);
            end
            @(posedge CLK); #1;
        end
        n_run++;
        if (InstrCount !== exp_cnt) begin
            n_fail++;
            $display("FAIL reset_count: cnt=%h, expected %h", InstrCount, exp_cnt);
        end
    endtask

    task automatic test_branch;
        exp_t e;
        logic [5:0]  ops [3] = '{6'b000100, 6'b000100, 6'b000101};
        logic        zs  [3] = '{1'b1, 1'b0, 1'b0};
        logic        tk  [3] = '{1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            PCCur = 32'h100; Zero = zs[i];
            Instr = {ops[i], 10'd0, 16'hFFFE};
            push(3'd0, 1'b1, 1'b1, 32'h104);
            push(3'd1, 1'b0, 1'b0, 32'h104);
            push(3'd2, tk[i], 1'b0, tk[i] ? 32'hFC : 32'h104);
            exp_cnt++;
            while (sb.size() != 0) begin
                e = sb.pop_front();
                @(negedge CLK);
                n_run++;
                if ({State, PCWE, IRWE, PCNext, Halted} !== {e.st, e.we, e.ir, e.pc, e.st == 3'd5}) begin
                    n_fail++;
                    $display("FAIL branch%0d: st=%0d we=%b ir=%b pc=%h hl=%b, expected st=%0d we=%b ir=%b pc=%h",
                             i, State, PCWE, IRWE, PCNext, Halted, e.st, e.we, e.ir, e.pc);
                end
                @(posedge CLK); #1;
            end
            n_run++;
            if ({State, InstrCount} !== {3'd0, exp_cnt}) begin
                n_fail++;
                $display("FAIL branch%0d_count: st=%0d cnt=%h, expected st=0 cnt=%h", i, State, InstrCount, exp_cnt);
            end
        end
    endtask

    task automatic test_multicycle;
        exp_t e;
        logic [31:0] ins [3] = '{I_LW, {6'b101011, 26'd0}, {6'b000000, 20'd0, 6'b100000}};
        logic [2:0]  sq  [3][5] = '{'{3'd0, 3'd1, 3'd2, 3'd3, 3'd4},
                                    '{3'd0, 3'd1, 3'd2, 3'd3, 3'd7},
                                    '{3'd0, 3'd1, 3'd2, 3'd4, 3'd7}};
        for (int i = 0; i < 3; i++) begin
            PCCur = 32'h1000; Instr = ins[i];
            for (int k = 0; k < 5; k++)
                if (sq[i][k] != 3'd7)
                    push(sq[i][k], k == 0, k == 0, 32'h1004);
            exp_cnt++;
            while (sb.size() != 0) begin
                e = sb.pop_front();
                @(negedge CLK);
                n_run++;
                if ({State, PCWE, IRWE, PCNext, Halted} !== {e.st, e.we, e.ir, e.pc, e.st == 3'd5}) begin
                    n_fail++;
                    $display("FAIL multi%0d: st=%0d we=%b ir=%b pc=%h hl=%b, expected st=%0d we=%b ir=%b pc=%h",
                             i, State, PCWE, IRWE, PCNext, Halted, e.st, e.we, e.ir, e.pc);
                end
                @(posedge CLK); #1;
            end
            n_run++;
            if ({State, InstrCount} !== {3'd0, exp_cnt}) begin
                n_fail++;
                $display("FAIL multi%0d_count: st=%0d cnt=%h, expected st=0 cnt=%h", i, State, InstrCount, exp_cnt);
            end
        end
    endtask

    task automatic test_jump;
        exp_t e;
        PCCur = 32'hA000_0000; RegA = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0:       Instr = {6'b000010, 26'h40};
                1:       Instr = {6'b000000, 5'd3, 15'd0, 6'b001000};
                default: Instr = {6'b000011, 26'h40};
            endcase
            push(3'd0, 1'b1, 1'b1, 32'hA000_0004);
            push(3'd1, 1'b1, 1'b0, (i == 1) ? 32'h1234_5678 : 32'hA000_0100);
            if (i == 2) push(3'd4, 1'b0, 1'b0, 32'hA000_0004);
            exp_cnt++;
            while (sb.size() != 0) begin
                e = sb.pop_front();
                @(negedge CLK);
                n_run++;
                if ({State, PCWE, IRWE, PCNext, Halted} !== {e.st, e.we, e.ir, e.pc, e.st == 3'd5}) begin
                    n_fail++;
                    $display("FAIL jump%0d: st=%0d we=%b ir=%b pc=%h hl=%b, expected st=%0d we=%b ir=%b pc=%h",
                             i, State, PCWE, IRWE, PCNext, Halted, e.st, e.we, e.ir, e.pc);
                end
                @(posedge CLK); #1;
            end
            n_run++;
            if ({State, InstrCount} !== {3'd0, exp_cnt}) begin
                n_fail++;
                $display("FAIL jump%0d_count: st=%0d cnt=%h, expected st=0 cnt=%h", i, State, InstrCount, exp_cnt);
            end
        end
    endtask

    task automatic test_halt;
        exp_t e;
        PCCur = 32'h300; Instr = I_HALT;
        push(3'd0, 1'b1, 1'b1, 32'h304);
        push(3'd1, 1'b0, 1'b0, 32'h304);
        for (int k = 0; k < 12; k++) push(3'd5, 1'b0, 1'b0, 32'h304);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            @(negedge CLK);
            n_run++;
            if ({State, PCWE, IRWE, PCNext, Halted, InstrCount} !==
                {e.st, e.we, e.ir, e.pc, e.st == 3'd5, exp_cnt}) begin
                n_fail++;
                $display("FAIL halt: st=%0d we=%b ir=%b pc=%h hl=%b cnt=%h, expected st=%0d we=%b ir=%b pc=%h cnt=%h",
                         State, PCWE, IRWE, PCNext, Halted, InstrCount, e.st, e.we, e.ir, e.pc, exp_cnt);
            end
            @(posedge CLK); #1;
        end
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0; Instr = I_NOP;
        exp_cnt = 32'd0;
        n_run++;
        if ({State, Halted, InstrCount} !== {3'd0, 1'b0, exp_cnt}) begin
            n_fail++;
            $display("FAIL halt_exit: st=%0d hl=%b cnt=%h, expected st=0 hl=0 cnt=0", State, Halted, InstrCount);
        end
    endtask

    task automatic test_reset_mid;
        exp_t e;
        PCCur = 32'h200; Instr = I_LW;
        repeat (3) begin @(posedge CLK); #1; end
        RST = 1'b1;
        @(negedge CLK);
        n_run++;
        if ({State, PCWE, IRWE} !== {3'd3, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_mem: st=%0d we=%b ir=%b, expected st=3 we=0 ir=0", State, PCWE, IRWE);
        end
        @(posedge CLK); #1;
        RST = 1'b0; Instr = I_NOP;
        exp_cnt = 32'd0;
        n_run++;
        if ({State, InstrCount} !== {3'd0, exp_cnt}) begin
            n_fail++;
            $display("FAIL reset_mem_state: st=%0d cnt=%h, expected st=0 cnt=0", State, InstrCount);
        end
        push(3'd0, 1'b1, 1'b1, 32'h204);
        push(3'd1, 1'b0, 1'b0, 32'h204);
        exp_cnt++;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            @(negedge CLK);
            n_run++;
            if ({State, PCWE, IRWE, PCNext, Halted} !== {e.st, e.we, e.ir, e.pc, e.st == 3'd5}) begin
                n_fail++;
                $display("FAIL reset_mem_resume: st=%0d we=%b ir=%b pc=%h hl=%b, expected st=%0d we=%b ir=%b pc=%h",
                         State, PCWE, IRWE, PCNext, Halted, e.st, e.we, e.ir, e.pc);
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_wrap;
        force dut.cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.cnt_q;
        PCCur = 32'h400; Instr = I_NOP;
        repeat (2) begin @(posedge CLK); #1; end
        n_run++;
        if ({State, InstrCount} !== {3'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL count_wrap: st=%0d cnt=%h, expected st=0 cnt=00000000", State, InstrCount);
        end
    endtask

    initial begin
        test_reset;
        test_branch;
        test_multicycle;
        test_jump;
        test_halt;
        test_reset_mid;
        test_wrap;
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have one clock and use a synchronous, active-high reset.
REQ-002 CLK  input  1  clock; all state changes on rising edge.
REQ-003 RST  input  1  synchronous reset, active-high.
REQ-004 PCCur  input  32  current PC register value.
REQ-005 Instr  input  32  instruction register contents; opcode [31:26], funct [5:0], imm16 [15:0], target [25:0].
REQ-006 Zero  input  1  ALU zero flag, valid in EXE.
REQ-007 RegA  input  32  rs register value, for jr.
REQ-008 PCNext  output  32  value to load into the PC register.
REQ-009 PCWE  output  1  PC write enable.
REQ-010 IRWE  output  1  instruction register write enable.
REQ-011 State  output  3  current state: IF=0, ID=1, EXE=2, MEM=3, WB=4, HALT=5.
REQ-012 Halted  output  1  high while State==HALT.
REQ-013 InstrCount  output  32  retired-instruction counter.

Function
REQ-014 PCWE, PCNext and IRWE SHALL be combinational from State, Instr, Zero, RegA, PCCur and the internal register PC4; the PC register SHALL sample them at the end of the cycle.
REQ-015 In IF: IRWE=1, PCWE=1, PCNext=PCCur+4 (mod 2^32); PC4<=PCCur+4; next state ID.
REQ-016 Outside IF, IRWE SHALL be 0; outside the cases in REQ-015, REQ-017, REQ-018, REQ-019 and REQ-021, PCWE SHALL be 0 and PCNext SHALL equal PC4.
REQ-017 ID, opcode 000010 (j): PCWE=1, PCNext={PC4[31:28],target,2'b00}; next IF.
REQ-018 ID, opcode 000011 (jal): PCWE=1, PCNext as for j; next WB (link write).
REQ-019 ID, opcode 000000 with funct 001000 (jr): PCWE=1, PCNext=RegA; next IF.
REQ-020 ID next state for other opcodes: 000000 (R-type) EXE; 100011 (lw) EXE; 101011 (sw) EXE; 000100 (beq) EXE; 000101 (bne) EXE; 111111 (halt) HALT; any other opcode IF (treated as nop).
REQ-021 EXE for beq with Zero=1, or bne with Zero=0: PCWE=1, PCNext=PC4+({{14{imm16[15]}},imm16,2'b00}) mod 2^32; for both branches the next state SHALL be IF regardless of Zero.
REQ-022 EXE next state: R-type WB; lw and sw MEM.
REQ-023 MEM next state: lw WB; sw IF.
REQ-024 WB next state SHALL be IF.
REQ-025 HALT SHALL be absorbing: PCWE=0, IRWE=0, Halted=1; it SHALL be left only via RST.
REQ-026 InstrCount SHALL increment by 1, wrapping 0xFFFFFFFF->0, on every transition into IF from a state other than IF; it SHALL hold in HALT; entering HALT SHALL NOT count.
REQ-027 Instr SHALL be treated as stable from ID onward; the block SHALL decode Instr combinationally in every state.
REQ-028 Encoding 6 and 7 on State SHALL be unreachable; if reached, the next state SHALL be IF with PCWE=0.

Reset
REQ-029 When RST=1 at a rising edge: State<=IF, PC4<=0, InstrCount<=0; pending instruction abandoned, from any state including HALT.
REQ-030 While RST=1, PCWE=0 and IRWE=0 SHALL hold, regardless of State.
REQ-031 First cycle after RST deasserts SHALL be an IF cycle with PCWE=1.

Verification
REQ-032 Reset, then PCCur=0x00000000 in IF -> PCNext=0x00000004, PCWE=1, IRWE=1; State 0->1.
REQ-033 beq, PCCur=0x00000100, imm16=0xFFFE, Zero=1 -> in EXE PCNext=0x000000FC, PCWE=1; with Zero=0 -> PCWE=0 in EXE, back to IF; InstrCount +1 in both cases.
REQ-034 lw sequence -> States 0,1,2,3,4,0 over 5 cycles, PCWE high only in IF; sw -> 0,1,2,3,0; R-type add -> 0,1,2,4,0.
REQ-035 j target=0x0000040, PC4=0xA0000004 -> in ID PCNext=0xA0000100; jr RegA=0x12345678 -> PCNext=0x12345678; jal -> ID then WB.
REQ-036 halt opcode -> State=5, Halted=1, PCWE=0 for 10+ cycles, InstrCount frozen; RST=1 for one cycle -> State=0, InstrCount=0.
REQ-037 RST asserted during MEM of lw -> next cycle State=IF, PCWE=0 while RST=1; preload InstrCount=0xFFFFFFFF (force) then retire one nop -> 0x00000000.
